// File: rtl/alarm_clock_core.sv
// Time-of-day engine: h:m:s timekeeping, time/alarm set modes, 12/24 h display, alarm with snooze and auto-silence.
// Display outputs are combinational from registered state (0 cycles); no backpressure, buttons are single-cycle pulses.
module alarm_clock_core #(
    parameter int CLK_FREQ   = 100000000,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sec_clr,
    input  logic       sw_12h,
    input  logic       alarm_en,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic       pm,
    output logic [2:0] mode,
    output logic       alarm_ring,
    output logic       sec_tick
);
    localparam int PW = $clog2(CLK_FREQ);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } mode_t;

    mode_t         mode_q, mode_d;
    logic [PW-1:0] presc;
    logic [4:0]    cur_hour, al_hour, snz_hour;
    logic [5:0]    cur_min, cur_sec, al_min, snz_min;
    logic          snz_vld, ring_q, tick_q;
    logic [7:0]    ring_cnt;

    logic          hold, tick_ev, edit, sec_wrap, min_wrap, trig, al_match, snz_match, ring_done;
    logic [5:0]    n_sec, n_min, snz_min_d;
    logic [4:0]    n_hour, snz_hour_d, hour_inc;
    logic [6:0]    snz_sum;
    logic [8:0]    cnt_nxt;

    // Up/down by one with modular wrap between 0 and top.
    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] top, input logic up);
        if (up) return (v == top) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    always_comb begin
        hold      = sec_clr | (mode_q == SET_H) | (mode_q == SET_M);
        tick_ev   = ~hold & (presc == PW'(CLK_FREQ - 1));
        edit      = btn_up ^ btn_down;
        sec_wrap  = (cur_sec == 6'd59);
        min_wrap  = (cur_min == 6'd59);
        hour_inc  = (cur_hour == 5'd23) ? 5'd0 : cur_hour + 5'd1;
        n_sec     = sec_wrap ? 6'd0 : cur_sec + 6'd1;
        n_min     = sec_wrap ? (min_wrap ? 6'd0 : cur_min + 6'd1) : cur_min;
        n_hour    = (sec_wrap && min_wrap) ? hour_inc : cur_hour;
        al_match  = (n_hour == al_hour) && (n_min == al_min);
        snz_match = snz_vld && (n_hour == snz_hour) && (n_min == snz_min);
        // A button press in the same cycle takes precedence over the trigger.
        trig      = tick_ev && (n_sec == 6'd0) && alarm_en && (mode_q == RUN)
                    && !btn_mode && !btn_up && (al_match || snz_match);
        snz_sum    = {1'b0, cur_min} + 7'(SNOOZE_MIN);
        snz_min_d  = (snz_sum >= 7'd60) ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
        snz_hour_d = (snz_sum >= 7'd60) ? hour_inc : cur_hour;
        cnt_nxt    = {1'b0, ring_cnt} + 9'd1;
        ring_done  = (cnt_nxt >= 9'(RING_SEC));
    end

    always_comb begin
        mode_d = mode_q;
        if (btn_mode && !ring_q) begin
            case (mode_q)
                RUN:     mode_d = SET_H;
                SET_H:   mode_d = SET_M;
                SET_M:   mode_d = SET_AH;
                SET_AH:  mode_d = SET_AM;
                default: mode_d = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) mode_q <= RUN;
        else             mode_q <= mode_d;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            presc    <= '0;
            tick_q   <= 1'b0;
            cur_hour <= 5'd0;
            cur_min  <= 6'd0;
            cur_sec  <= 6'd0;
            al_hour  <= 5'd7;
            al_min   <= 6'd0;
        end else begin
            tick_q <= tick_ev;
            if (hold) begin
                presc   <= '0;
                cur_sec <= 6'd0;
            end else if (tick_ev) begin
                presc    <= '0;
                cur_sec  <= n_sec;
                cur_min  <= n_min;
                cur_hour <= n_hour;
            end else begin
                presc <= presc + PW'(1);
            end
            // Time edits only happen while held, so they never collide with a carry.
            if (edit) begin
                case (mode_q)
                    SET_H:   cur_hour <= 5'(step_wrap({1'b0, cur_hour}, 6'd23, btn_up));
                    SET_M:   cur_min  <= step_wrap(cur_min, 6'd59, btn_up);
                    SET_AH:  al_hour  <= 5'(step_wrap({1'b0, al_hour}, 6'd23, btn_up));
                    SET_AM:  al_min   <= step_wrap(al_min, 6'd59, btn_up);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ring_q   <= 1'b0;
            ring_cnt <= 8'd0;
            snz_vld  <= 1'b0;
            snz_hour <= 5'd0;
            snz_min  <= 6'd0;
        end else if (!alarm_en) begin
            ring_q  <= 1'b0;
            snz_vld <= 1'b0;
        end else if (ring_q && btn_mode) begin
            ring_q  <= 1'b0;
            snz_vld <= 1'b0;
        end else if (ring_q && btn_up) begin
            ring_q   <= 1'b0;
            snz_vld  <= 1'b1;
            snz_hour <= snz_hour_d;
            snz_min  <= snz_min_d;
        end else if (trig) begin
            ring_q   <= 1'b1;
            ring_cnt <= 8'd0;
            if (snz_match) snz_vld <= 1'b0;
        end else if (ring_q && tick_ev) begin
            ring_cnt <= cnt_nxt[7:0];
            if (ring_done) ring_q <= 1'b0;
        end
    end

    logic       alarm_view;
    logic [4:0] src_hour;

    always_comb begin
        alarm_view = (mode_q == SET_AH) || (mode_q == SET_AM);
        src_hour   = alarm_view ? al_hour : cur_hour;
        disp_min   = alarm_view ? al_min : cur_min;
        disp_sec   = alarm_view ? 6'd0 : cur_sec;
        pm         = (src_hour >= 5'd12);
        disp_hour  = src_hour;
        if (sw_12h) begin
            if (src_hour == 5'd0)       disp_hour = 5'd12;
            else if (src_hour > 5'd12)  disp_hour = src_hour - 5'd12;
        end
    end

    assign mode       = mode_q;
    assign alarm_ring = ring_q;
    assign sec_tick   = tick_q;
endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core with CLK_FREQ=10: directed scenarios plus random button traffic,
// every cycle compared against a seconds-of-day reference model.
module tb_alarm_clock_core;
    localparam int CLK = 10;

    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN, btn_mode, btn_up, btn_down, sec_clr, sw_12h, alarm_en;
    logic [4:0] disp_hour;
    logic [5:0] disp_min, disp_sec;
    logic       pm, alarm_ring, sec_tick;
    logic [2:0] mode;

    alarm_clock_core #(.CLK_FREQ(CLK), .SNOOZE_MIN(5), .RING_SEC(60)) dut (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .sec_clr   (sec_clr),
        .sw_12h    (sw_12h),
        .alarm_en  (alarm_en),
        .disp_hour (disp_hour),
        .disp_min  (disp_min),
        .disp_sec  (disp_sec),
        .pm        (pm),
        .mode      (mode),
        .alarm_ring(alarm_ring),
        .sec_tick  (sec_tick)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_chk = 0;
    int n_pass = 0;

    // Reference state: time as seconds of day, alarm/snooze as minutes of day (-1 = no snooze).
    int m_t, m_alarm, m_snz, m_presc, m_rcnt, m_md;
    bit m_ring, m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_t = 0; m_alarm = 7 * 60; m_snz = -1; m_presc = 0;
        m_rcnt = 0; m_md = 0; m_ring = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        int h, m, nt, d, old_min;
        bit hold, tk, trig;
        hold    = sec_clr || m_md == 1 || m_md == 2;
        tk      = !hold && (m_presc == CLK - 1);
        old_min = m_t / 60;
        nt      = m_t;
        if (hold)    nt = m_t - m_t % 60;
        else if (tk) nt = (m_t + 1) % 86400;
        if (btn_up != btn_down) begin
            d = btn_up ? 1 : -1;
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            case (m_md)
                1: nt = ((h + d + 24) % 24) * 3600 + m * 60;
                2: nt = h * 3600 + ((m + d + 60) % 60) * 60;
                3: m_alarm = ((m_alarm / 60 + d + 24) % 24) * 60 + m_alarm % 60;
                4: m_alarm = (m_alarm / 60) * 60 + (m_alarm % 60 + d + 60) % 60;
                default: ;
            endcase
        end
        m_presc = (hold || tk) ? 0 : m_presc + 1;
        trig = tk && (nt % 60 == 0) && alarm_en && m_md == 0 && !btn_mode && !btn_up
               && (nt / 60 == m_alarm || nt / 60 == m_snz);
        if (btn_mode && !m_ring) m_md = (m_md + 1) % 5;
        if (!alarm_en) begin
            m_ring = 0; m_snz = -1;
        end else if (m_ring && btn_mode) begin
            m_ring = 0; m_snz = -1;
        end else if (m_ring && btn_up) begin
            m_ring = 0; m_snz = (old_min + 5) % 1440;
        end else if (trig) begin
            m_ring = 1; m_rcnt = 0;
            if (nt / 60 == m_snz) m_snz = -1;
        end else if (m_ring && tk) begin
            m_rcnt++;
            if (m_rcnt >= 60) m_ring = 0;
        end
        m_t    = nt;
        m_tick = tk;
    endtask

    function automatic logic [31:0] exp_vec();
        int h, m, s, dh;
        if (m_md >= 3) begin
            h = m_alarm / 60; m = m_alarm % 60; s = 0;
        end else begin
            h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        end
        dh = sw_12h ? (h == 0 ? 12 : (h > 12 ? h - 12 : h)) : h;
        return {9'd0, 5'(dh), 6'(m), 6'(s), (h >= 12), 3'(m_md), m_ring, m_tick};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {9'd0, disp_hour, disp_min, disp_sec, pm, mode, alarm_ring, sec_tick};
    endfunction

    function automatic int dut_time();
        return int'(disp_hour) * 3600 + int'(disp_min) * 60 + int'(disp_sec);
    endfunction

    task automatic step();
        model_edge();
        @(posedge CLK100MHZ);
        #1;
        chk("cycle", dut_vec(), exp_vec());
    endtask

    task automatic press(input bit bm, input bit bu, input bit bd);
        btn_mode = bm; btn_up = bu; btn_down = bd;
        step();
        btn_mode = 0; btn_up = 0; btn_down = 0;
    endtask

    task automatic run_until_time(input string tag, input int target);
        int n = 0;
        while (m_t != target && n < 5000) begin
            step();
            n++;
        end
        chk(tag, dut_time(), target);
    endtask

    task automatic run_until_tick(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_tick && n < 30);
        chk(tag, sec_tick, 1);
    endtask

    // Called right after step(): drops reset between clock edges and checks outputs at once.
    task automatic async_reset_check(input string tag);
        #1;
        CPU_RESETN = 0;
        model_reset();
        #1;
        chk(tag, dut_vec(), exp_vec());
        chk({tag, "_hour"}, disp_hour, 0);
        #1;
        CPU_RESETN = 1;
    endtask

    task automatic set_time_0659();
        press(1, 0, 0);
        for (int i = 0; i < 6; i++) press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        repeat (3) press(1, 0, 0);
    endtask

    initial begin
        int ticks, nt, n;
        CPU_RESETN = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
        sec_clr = 0; sw_12h = 0; alarm_en = 0;
        model_reset();
        @(posedge CLK100MHZ);
        #1;
        chk("reset_state", dut_vec(), 32'd0);
        sw_12h = 1;
        #1;
        chk("reset_hour_12h", disp_hour, 12);
        sw_12h = 0;
        CPU_RESETN = 1;

        // Free run for one minute.
        ticks = 0;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (sec_tick) ticks++;
            if (i == 10) chk("first_tick", sec_tick, 1);
        end
        chk("minute_ticks", ticks, 60);
        chk("minute_time", dut_time(), 60);

        // Preload 23:59 then roll over midnight.
        press(1, 0, 0);
        press(0, 0, 1);
        chk("hour_wrap_down", disp_hour, 23);
        press(1, 0, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        chk("min_wrap_down", disp_min, 59);
        repeat (3) press(1, 0, 0);
        run_until_time("reach_235959", 86399);
        run_until_tick("midnight_tick");
        sw_12h = 1;
        #1;
        chk("midnight_12h", {disp_hour, disp_min, disp_sec, pm}, {5'd12, 6'd0, 6'd0, 1'b0});
        sw_12h = 0;

        // Minute editing without carry.
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("setm_down", {disp_hour, disp_min}, {5'd0, 6'd59});
        press(0, 1, 0);
        chk("setm_up_nocarry", {disp_hour, disp_min}, {5'd0, 6'd0});
        press(0, 0, 1);
        press(0, 1, 1);
        chk("setm_both", {disp_min, disp_sec}, {6'd59, 6'd0});
        press(1, 0, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!sec_tick && n < 20);
        chk("resume_latency", n, 10);
        press(1, 0, 0);
        press(1, 0, 0);

        // Alarm at 07:00 and auto-silence.
        set_time_0659();
        alarm_en = 1;
        run_until_time("reach_065959", 6 * 3600 + 59 * 60 + 59);
        run_until_tick("alarm_tick");
        chk("alarm_fire", {alarm_ring, disp_hour, disp_min}, {1'b1, 5'd7, 6'd0});
        nt = 0; n = 0;
        while (nt < 60 && n < 1000) begin
            step();
            n++;
            if (sec_tick) begin
                nt++;
                if (nt == 59) chk("ring_before_end", alarm_ring, 1);
            end
        end
        chk("ring_ticks", nt, 60);
        chk("ring_auto_off", alarm_ring, 0);

        // Snooze then dismiss.
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        repeat (3) press(1, 0, 0);
        run_until_time("reach_065959b", 6 * 3600 + 59 * 60 + 59);
        run_until_tick("alarm_tick2");
        chk("alarm_fire2", alarm_ring, 1);
        press(0, 1, 0);
        chk("snooze_off", {alarm_ring, disp_hour}, {1'b0, 5'd7});
        run_until_time("reach_0705", 7 * 3600 + 5 * 60);
        chk("snooze_fire", alarm_ring, 1);
        press(1, 0, 0);
        chk("dismiss", {alarm_ring, mode}, {1'b0, 3'd0});

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            btn_mode = ($urandom_range(199) == 0);
            btn_up   = ($urandom_range(29) == 0);
            btn_down = ($urandom_range(29) == 0);
            if ($urandom_range(299) == 0) sec_clr = ~sec_clr;
            if ($urandom_range(499) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(99) == 0) sw_12h = ~sw_12h;
            step();
            btn_mode = 0; btn_up = 0; btn_down = 0;
        end
        sec_clr = 0; sw_12h = 0; alarm_en = 1;
        step();

        // Asynchronous reset while ringing and while in an alarm set mode.
        async_reset_check("reset_sync");
        set_time_0659();
        run_until_time("reach_065959c", 6 * 3600 + 59 * 60 + 59);
        run_until_tick("alarm_tick3");
        chk("alarm_fire3", alarm_ring, 1);
        async_reset_check("reset_ringing");
        repeat (3) press(1, 0, 0);
        press(0, 1, 0);
        chk("set_ah", {mode, disp_hour}, {3'd3, 5'd8});
        async_reset_check("reset_set_ah");
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
